imem_port_arbiter: RTL and testbench

Sequences and shares the single-port 256-byte instruction BRAM (64 words × 32 bits) between the fetch stage and the debug loader. Fetch reads stream at one word per cycle. Debug reads and writes get priority in debug mode. Outside debug mode they are served in idle slots, with a bounded-wait guarantee. The block sits between the fetch pipeline stage, the debug I/O controller and the BRAM instance, and drives every BRAM port.

---
 rtl/imem_port_arbiter.sv | 116 +++++++++++
 tb/tb_imem_port_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_port_arbiter.sv
// Shares the single-port 64x32 instruction BRAM between fetch and the debug loader.
// IMEM_DBG_READBACK_EN: when defined, debug reads access the BRAM; otherwise they ack with zero.
module imem_port_arbiter #(
  parameter int unsigned WAIT_MAX = 7
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic        debug,
  input  logic        f_req,
  input  logic [7:0]  f_addr,
  output logic        f_stall,
  output logic        f_valid,
  output logic [31:0] f_ins,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [7:0]  dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_ack,
  output logic [31:0] dbg_rdata,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [5:0]  mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout
);

  localparam logic [2:0] WaitMax = 3'(WAIT_MAX);

  typedef enum logic [1:0] {StIdle, StFetch, StDbgRd, StDbgWr} state_e;

  state_e     state_q, state_d;
  logic [2:0] wait_q, wait_d;
  logic       nrb_ack_q;

  logic dbg_busy, dbg_elig, dbg_slot, dbg_nrb, dbg_win, f_win;
  logic unused_addr_bits;

  assign unused_addr_bits = ^{f_addr[1:0], dbg_addr[1:0]};

  always_comb begin
    // No new debug grant while its previous op is still being acked.
    dbg_busy = (state_q == StDbgRd) || (state_q == StDbgWr) || nrb_ack_q;
    dbg_elig = dbg_req && !dbg_busy;
`ifdef IMEM_DBG_READBACK_EN
    dbg_slot = dbg_elig;
    dbg_nrb  = 1'b0;
`else
    // Reads need no BRAM slot: accepted at once, alongside any fetch.
    dbg_slot = dbg_elig && dbg_we;
    dbg_nrb  = dbg_elig && !dbg_we;
`endif
    dbg_win = dbg_slot && (debug || !f_req || (wait_q == WaitMax));
    f_win   = f_req && !dbg_win;

    if (dbg_win) begin
      state_d = dbg_we ? StDbgWr : StDbgRd;
    end else if (f_win) begin
      state_d = StFetch;
    end else begin
      state_d = StIdle;
    end

    if (!dbg_req || dbg_win || dbg_nrb) begin
      wait_d = 3'd0;
    end else if (dbg_slot && (wait_q != WaitMax)) begin
      wait_d = wait_q + 3'd1;
    end else begin
      wait_d = wait_q;
    end
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q   <= StIdle;
      wait_q    <= 3'd0;
      nrb_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      nrb_ack_q <= dbg_nrb;
    end
  end

  always_comb begin
    f_stall   = 1'b0;
    f_valid   = 1'b0;
    f_ins     = 32'd0;
    dbg_ack   = 1'b0;
    dbg_rdata = 32'd0;
    mem_en    = 1'b0;
    mem_we    = 4'b0000;
    mem_addr  = 6'd0;
    mem_din   = 32'd0;
    if (!Rst) begin
      f_stall = f_req && !f_win;
      mem_en  = dbg_win || f_win;
      if (dbg_win) begin
        mem_addr = dbg_addr[7:2];
        if (dbg_we) begin
          mem_we  = 4'b1111;
          mem_din = dbg_wdata;
        end
      end else if (f_win) begin
        mem_addr = f_addr[7:2];
      end

      f_valid = (state_q == StFetch);
      f_ins   = f_valid ? mem_dout : 32'd0;
      dbg_ack = dbg_busy;
      if (state_q == StDbgRd) begin
        dbg_rdata = mem_dout;
      end
    end
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a BRAM model and a return-data scoreboard.
// Expectations for debug reads follow IMEM_DBG_READBACK_EN.
module tb_imem_port_arbiter;

  localparam int unsigned WM = 7;

  logic        clk;
  logic        Rst;
  logic        debug;
  logic        f_req;
  logic [7:0]  f_addr;
  logic        f_stall;
  logic        f_valid;
  logic [31:0] f_ins;
  logic        dbg_req;
  logic        dbg_we;
  logic [7:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_ack;
  logic [31:0] dbg_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  imem_port_arbiter #(.WAIT_MAX(WM)) dut (
    .clk       (clk),
    .Rst       (Rst),
    .debug     (debug),
    .f_req     (f_req),
    .f_addr    (f_addr),
    .f_stall   (f_stall),
    .f_valid   (f_valid),
    .f_ins     (f_ins),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_ack   (dbg_ack),
    .dbg_rdata (dbg_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int i);
    return 32'hC0DE0000 | 32'(i * 37 + 5);
  endfunction

  // BRAM model, preloaded while preload=1
  logic [31:0] bram [64];
  logic        preload;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) bram[i] <= init_word(i);
    end else if (mem_en) begin
      if (mem_we == 4'b1111) bram[mem_addr] <= mem_din;
      mem_dout <= bram[mem_addr];
    end
  end

  typedef struct {
    int          due;
    int          kind;   // 1 fetch return, 2 debug ack
    logic [31:0] data;
  } sb_t;

  sb_t         sb[$];
  logic [31:0] shadow [64];
  int          total;
  int          bad;
  int          cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Rst=1 with busy inputs: every output must read zero, in-flight returns are dropped.
  task automatic reset_cycle();
    @(posedge clk);
    #1;
    cyc++;
    Rst = 1'b1; debug = 1'b1; f_req = 1'b1; f_addr = 8'h44;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h08; dbg_wdata = 32'hFFFFFFFF;
    #1;
    chk("rst_f_stall", 32'(f_stall), 32'd0);
    chk("rst_f_valid", 32'(f_valid), 32'd0);
    chk("rst_f_ins", f_ins, 32'd0);
    chk("rst_dbg_ack", 32'(dbg_ack), 32'd0);
    chk("rst_dbg_rdata", dbg_rdata, 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_din", mem_din, 32'd0);
    sb.delete();
  endtask

  // dk: 0 none, 2 debug BRAM read, 3 debug write, 4 debug read acked without BRAM
  task automatic step(input logic dm, input logic freq, input logic [7:0] fa,
                      input logic dreq, input logic dwe, input logic [7:0] da,
                      input logic [31:0] dwd, input logic fk, input int dk,
                      input logic st);
    logic        exp_fv, exp_ack, exp_en;
    logic [31:0] exp_fi, exp_rd;
    logic [5:0]  exp_addr;
    sb_t         e;
    @(posedge clk);
    #1;
    cyc++;
    Rst = 1'b0; debug = dm; f_req = freq; f_addr = fa;
    dbg_req = dreq; dbg_we = dwe; dbg_addr = da; dbg_wdata = dwd;
    #1;
    exp_fv = 1'b0; exp_fi = 32'd0; exp_ack = 1'b0; exp_rd = 32'd0;
    while (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      if (e.kind == 1) begin
        exp_fv = 1'b1; exp_fi = e.data;
      end else begin
        exp_ack = 1'b1; exp_rd = e.data;
      end
    end
    chk("f_valid", 32'(f_valid), 32'(exp_fv));
    chk("f_ins", f_ins, exp_fi);
    chk("dbg_ack", 32'(dbg_ack), 32'(exp_ack));
    chk("dbg_rdata", dbg_rdata, exp_rd);

    exp_en   = fk || dk == 2 || dk == 3;
    exp_addr = (dk == 2 || dk == 3) ? da[7:2] : fa[7:2];
    chk("mem_en", 32'(mem_en), 32'(exp_en));
    if (exp_en) chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
    chk("mem_we", 32'(mem_we), (dk == 3) ? 32'hF : 32'h0);
    chk("mem_din", mem_din, (dk == 3) ? dwd : 32'd0);
    chk("f_stall", 32'(f_stall), 32'(st));

    if (fk) sb.push_back('{cyc + 1, 1, shadow[fa[7:2]]});
    if (dk == 2) sb.push_back('{cyc + 1, 2, shadow[da[7:2]]});
    if (dk == 3) begin
      sb.push_back('{cyc + 1, 2, 32'd0});
      shadow[da[7:2]] = dwd;
    end
    if (dk == 4) sb.push_back('{cyc + 1, 2, 32'd0});
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0;
    preload = 1'b1;
    Rst = 1'b1; debug = 1'b0; f_req = 1'b0; f_addr = 8'h00;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 8'h00; dbg_wdata = 32'd0;
    for (int i = 0; i < 64; i++) shadow[i] = init_word(i);
    reset_cycle();
    preload = 1'b0;
    reset_cycle();

    // Fetch stream straight out of reset
    step(0, 1, 8'h00, 0, 0, 8'h00, 32'd0, 1, 0, 0);
    step(0, 1, 8'h04, 0, 0, 8'h00, 32'd0, 1, 0, 0);
    step(0, 1, 8'h08, 0, 0, 8'h00, 32'd0, 1, 0, 0);
    step(0, 0, 8'h00, 0, 0, 8'h00, 32'd0, 0, 0, 0);

    // Debug mode: write beats fetch, fetch proceeds in the ack cycle
    step(1, 1, 8'h20, 1, 1, 8'h10, 32'hDEADBEEF, 0, 3, 1);
    step(1, 1, 8'h20, 1, 1, 8'h10, 32'hDEADBEEF, 1, 0, 0);
`ifdef IMEM_DBG_READBACK_EN
    step(1, 1, 8'h24, 1, 0, 8'h10, 32'd0, 0, 2, 1);
    step(1, 1, 8'h24, 1, 0, 8'h10, 32'd0, 1, 0, 0);
`else
    step(1, 1, 8'h24, 1, 0, 8'h10, 32'd0, 1, 4, 0);
    step(1, 1, 8'h28, 1, 0, 8'h10, 32'd0, 1, 0, 0);
`endif
    step(0, 1, 8'h10, 0, 0, 8'h00, 32'd0, 1, 0, 0);

    // Idle slot outside debug mode, unaligned addresses and the top word
    step(0, 0, 8'h00, 1, 1, 8'h13, 32'hCAFEF00D, 0, 3, 0);
    step(0, 1, 8'h13, 1, 1, 8'h13, 32'hCAFEF00D, 1, 0, 0);
    step(0, 1, 8'hFC, 0, 0, 8'h00, 32'd0, 1, 0, 0);

    // Bounded wait: debug forced in on the (WM+1)th contended cycle
    for (int i = 0; i < int'(WM); i++) begin
      step(0, 1, 8'(4 * i), 1, 1, 8'h30, 32'h12345678, 1, 0, 0);
    end
    step(0, 1, 8'(4 * WM), 1, 1, 8'h30, 32'h12345678, 0, 3, 1);
    step(0, 1, 8'(4 * WM), 1, 1, 8'h30, 32'h12345678, 1, 0, 0);
    step(0, 1, 8'h30, 0, 0, 8'h00, 32'd0, 1, 0, 0);

    // Debug read in an idle slot
`ifdef IMEM_DBG_READBACK_EN
    step(0, 0, 8'h00, 1, 0, 8'hFC, 32'd0, 0, 2, 0);
`else
    step(0, 0, 8'h00, 1, 0, 8'hFC, 32'd0, 0, 4, 0);
`endif
    step(0, 0, 8'h00, 1, 0, 8'hFC, 32'd0, 0, 0, 0);
    step(0, 0, 8'h00, 0, 0, 8'h00, 32'd0, 0, 0, 0);

    // Reset right after a fetch grant discards its return
    step(0, 1, 8'h04, 0, 0, 8'h00, 32'd0, 1, 0, 0);
    reset_cycle();
    step(0, 0, 8'h00, 0, 0, 8'h00, 32'd0, 0, 0, 0);
    step(0, 1, 8'h08, 0, 0, 8'h00, 32'd0, 1, 0, 0);
    step(0, 0, 8'h00, 0, 0, 8'h00, 32'd0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
